// File: rtl/io_output_reg_pkg.sv
// Shared constants and op helper for the memory-mapped output port block.
package io_output_reg_pkg;

  localparam int unsigned IO_NUM_PORTS    = 3;
  localparam logic [5:0]  IO_OUT_BASE_IDX = 6'h20;
  localparam int unsigned IO_OP_LSB       = 8;

  typedef enum logic [1:0] {
    IO_OP_WRITE  = 2'b00,
    IO_OP_SET    = 2'b01,
    IO_OP_CLEAR  = 2'b10,
    IO_OP_TOGGLE = 2'b11
  } io_op_e;

  function automatic logic [31:0] io_apply_op(
    input io_op_e      op,
    input logic [31:0] cur,
    input logic [31:0] din
  );
    logic [31:0] res;
    unique case (op)
      IO_OP_WRITE:  res = din;
      IO_OP_SET:    res = cur | din;
      IO_OP_CLEAR:  res = cur & ~din;
      IO_OP_TOGGLE: res = cur ^ din;
      default:      res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/io_output_mux.sv
// Readback mux for the three output registers; returns zero on an index miss.
module io_output_mux
  import io_output_reg_pkg::*;
#(
  parameter logic [5:0] BASE_IDX = IO_OUT_BASE_IDX
) (
  input  logic [5:0]  idx,
  input  logic [31:0] port0,
  input  logic [31:0] port1,
  input  logic [31:0] port2,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (idx)
      BASE_IDX:         rdata = port0;
      BASE_IDX + 6'd1:  rdata = port1;
      BASE_IDX + 6'd2:  rdata = port2;
      default:          rdata = '0;
    endcase
  end

endmodule

// File: rtl/io_output_reg.sv
// Output port registers with write/set/clear/toggle aliases,
// combinational readback and a one-cycle update strobe per port.
module io_output_reg
  import io_output_reg_pkg::*;
#(
  parameter logic [5:0]  BASE_IDX   = IO_OUT_BASE_IDX,
  parameter logic [31:0] RESET_VAL0 = 32'h0,
  parameter logic [31:0] RESET_VAL1 = 32'h0,
  parameter logic [31:0] RESET_VAL2 = 32'h0
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  output logic [31:0] io_read_data,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [2:0]  out_strobe
);

  logic [5:0]              idx;
  io_op_e                  op;
  logic [31:0]             port_q    [IO_NUM_PORTS];
  logic [31:0]             port_d    [IO_NUM_PORTS];
  logic [31:0]             reset_val [IO_NUM_PORTS];
  logic [IO_NUM_PORTS-1:0] hit;
  logic [IO_NUM_PORTS-1:0] strobe_d;
  logic [IO_NUM_PORTS-1:0] strobe_q;
  logic                    unused_addr;

  assign idx         = addr[7:2];
  assign op          = io_op_e'(addr[IO_OP_LSB +: 2]);
  assign unused_addr = ^{addr[31:10], addr[1:0]};

  assign reset_val[0] = RESET_VAL0;
  assign reset_val[1] = RESET_VAL1;
  assign reset_val[2] = RESET_VAL2;

  always_comb begin
    hit      = '0;
    strobe_d = '0;
    for (int n = 0; n < IO_NUM_PORTS; n++) begin
      port_d[n]   = port_q[n];
      hit[n]      = (idx == BASE_IDX + 6'(n));
      strobe_d[n] = write_io_enable & hit[n];
      if (strobe_d[n])
        port_d[n] = io_apply_op(op, port_q[n], datain);
    end
  end

  // Reset wins over a same-cycle write, so no strobe either.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      for (int n = 0; n < IO_NUM_PORTS; n++)
        port_q[n] <= reset_val[n];
      strobe_q <= '0;
    end else begin
      for (int n = 0; n < IO_NUM_PORTS; n++)
        port_q[n] <= port_d[n];
      strobe_q <= strobe_d;
    end
  end

  io_output_mux #(
    .BASE_IDX (BASE_IDX)
  ) u_mux (
    .idx   (idx),
    .port0 (port_q[0]),
    .port1 (port_q[1]),
    .port2 (port_q[2]),
    .rdata (io_read_data)
  );

  assign out_port0  = port_q[0];
  assign out_port1  = port_q[1];
  assign out_port2  = port_q[2];
  assign out_strobe = strobe_q;

endmodule

// File: tb/tb_io_output_reg.sv
// Scoreboard bench for io_output_reg: directed cases then random traffic
// against an array-based model of the three ports.
module tb_io_output_reg;

  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'h0000_00FF;
  localparam logic [31:0] RV2 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] datain = '0;
  logic        write_io_enable = 1'b0;
  logic [31:0] io_read_data;
  logic [31:0] out_port0, out_port1, out_port2;
  logic [2:0]  out_strobe;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          v;
    logic [31:0] d;
  } rd_t;

  typedef struct {
    bit          v;
    logic [31:0] p0, p1, p2;
    logic [2:0]  s;
  } st_t;

  rd_t rd_q[$];
  st_t st_q[$];

  logic [31:0] m [3];
  bit          m_valid = 0;

  always #5 clk = ~clk;

  io_output_reg #(
    .BASE_IDX   (6'h20),
    .RESET_VAL0 (RV0),
    .RESET_VAL1 (RV1),
    .RESET_VAL2 (RV2)
  ) dut (
    .io_clk          (clk),
    .reset           (reset),
    .addr            (addr),
    .datain          (datain),
    .write_io_enable (write_io_enable),
    .io_read_data    (io_read_data),
    .out_port0       (out_port0),
    .out_port1       (out_port1),
    .out_port2       (out_port2),
    .out_strobe      (out_strobe)
  );

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, record expectations from the model.
  task automatic drive(input bit rst, input logic [31:0] a,
                       input logic [31:0] d, input bit we);
    int  n;
    rd_t r;
    st_t s;
    @(posedge clk);
    #2;
    reset = rst;
    addr = a;
    datain = d;
    write_io_enable = we;
    n = int'((a >> 2) & 32'h3F) - 32;
    r.v = m_valid;
    r.d = (n >= 0 && n < 3) ? m[n] : 32'h0;
    rd_q.push_back(r);
    s.s = 3'b000;
    if (rst) begin
      m[0] = RV0;
      m[1] = RV1;
      m[2] = RV2;
      m_valid = 1;
    end else if (we && n >= 0 && n < 3) begin
      case ((a >> 8) & 32'h3)
        0: m[n] = d;
        1: m[n] = m[n] | d;
        2: m[n] = m[n] & ~d;
        default: m[n] = m[n] ^ d;
      endcase
      s.s = 3'(1 << n);
    end
    s.v = m_valid;
    s.p0 = m[0];
    s.p1 = m[1];
    s.p2 = m[2];
    st_q.push_back(s);
  endtask

  initial begin : rd_mon
    rd_t r;
    forever begin
      @(negedge clk);
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        if (r.v) cmp("io_read_data", io_read_data, r.d);
      end
    end
  end

  initial begin : st_mon
    st_t s;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        if (s.v) begin
          cmp("out_port0", out_port0, s.p0);
          cmp("out_port1", out_port1, s.p1);
          cmp("out_port2", out_port2, s.p2);
          cmp("out_strobe", {29'h0, out_strobe}, {29'h0, s.s});
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] a;
    logic [5:0]  idx;
    drive(1, 32'h0, 32'h0, 0);
    drive(0, 32'h080, 32'h1234_5678, 1);
    drive(0, 32'h080, 32'h0, 0);
    drive(0, 32'h084, 32'h0000_00F0, 1);
    drive(0, 32'h184, 32'h0000_000F, 1);
    drive(0, 32'h284, 32'h0000_003C, 1);
    drive(0, 32'h384, 32'h0000_00FF, 1);
    drive(0, 32'h084, 32'h0, 0);
    drive(0, 32'h08C, 32'hFFFF_FFFF, 1);
    drive(0, 32'h0C0, 32'hFFFF_FFFF, 1);
    drive(0, 32'h088, 32'h0000_0055, 1);
    drive(1, 32'h088, 32'hDEAD_BEEF, 1);
    drive(0, 32'h088, 32'h0, 0);
    drive(0, 32'h080, 32'hAAAA_AAAA, 0);
    drive(0, 32'h080, 32'hAAAA_AAAA, 0);
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        idx = 6'(30 + $urandom_range(0, 7));
        a[7:2] = idx;
      end
      drive(($urandom_range(0, 39) == 0), a, $urandom,
            ($urandom_range(0, 3) != 0));
    end
    drive(0, 32'h0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
